alu_pipe: RTL and testbench

ALU_PIPE -- requirements
Module: alu_pipe

---
 rtl/alu_pipe_if.sv | 31 +++
 rtl/alu_pipe.sv | 184 ++++++++++++++++++
 tb/tb_alu_pipe.sv | 324 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_pipe_if.sv
// Handshake and data bundle between an ALU client (master) and alu_pipe (slave).
interface alu_pipe_if #(
  parameter int DATAPATH_WIDTH = 64,
  parameter int SHAMT_WIDTH    = 6
);
  logic                      op_valid_in;
  logic                      op_ready_out;
  logic [DATAPATH_WIDTH-1:0] a_in;
  logic [DATAPATH_WIDTH-1:0] b_in;
  logic [3:0]                alu_ctrl_in;
  logic [SHAMT_WIDTH-1:0]    shift_value;
  logic                      res_valid_out;
  logic                      res_ready_in;
  logic [DATAPATH_WIDTH-1:0] accum_out;
  logic                      zero_out;
  logic                      carry_out;
  logic                      ovf_out;
  logic                      busy_out;

  modport master (
    output op_valid_in, a_in, b_in, alu_ctrl_in, shift_value, res_ready_in,
    input  op_ready_out, res_valid_out, accum_out, zero_out, carry_out,
           ovf_out, busy_out
  );

  modport slave (
    input  op_valid_in, a_in, b_in, alu_ctrl_in, shift_value, res_ready_in,
    output op_ready_out, res_valid_out, accum_out, zero_out, carry_out,
           ovf_out, busy_out
  );
endinterface

// File: rtl/alu_pipe.sv
// Single-issue ALU: one-cycle ops go straight to DONE, MUL runs an iterative
// shift-add for DATAPATH_WIDTH cycles. The result and its flags are held in
// DONE until the consumer accepts them.
module alu_pipe #(
  parameter int DATAPATH_WIDTH = 64,
  parameter int SHAMT_WIDTH    = 6
) (
  input logic       clk,
  input logic       reset,
  alu_pipe_if.slave bus
);

  localparam int CW = (DATAPATH_WIDTH > 1) ? $clog2(DATAPATH_WIDTH) : 1;
  localparam int MSB = DATAPATH_WIDTH - 1;
  localparam logic [15:0] SENTINEL_WORD = 16'hDEAF;

  localparam logic [3:0] OP_SENT = 4'd0;
  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_AND  = 4'd3;
  localparam logic [3:0] OP_OR   = 4'd4;
  localparam logic [3:0] OP_NOT  = 4'd5;
  localparam logic [3:0] OP_XOR  = 4'd6;
  localparam logic [3:0] OP_SLTU = 4'd7;
  localparam logic [3:0] OP_SLL  = 4'd8;
  localparam logic [3:0] OP_SRL  = 4'd9;
  localparam logic [3:0] OP_SRA  = 4'd10;
  localparam logic [3:0] OP_SLT  = 4'd11;
  localparam logic [3:0] OP_MUL  = 4'd12;

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

  state_t                    state_reg;
  logic                      ready_reg;
  logic                      busy_reg;
  logic                      valid_reg;
  logic [DATAPATH_WIDTH-1:0] accum_reg;
  logic                      zero_reg;
  logic                      carry_reg;
  logic                      ovf_reg;
  logic [DATAPATH_WIDTH-1:0] mcand_reg;
  logic [DATAPATH_WIDTH-1:0] mplier_reg;
  logic [DATAPATH_WIDTH-1:0] prod_reg;
  logic [CW-1:0]             cnt_reg;

  logic [DATAPATH_WIDTH-1:0] sentinel;
  logic [DATAPATH_WIDTH-1:0] result_next;
  logic                      carry_next;
  logic                      ovf_next;
  logic [DATAPATH_WIDTH:0]   add_full;
  logic [DATAPATH_WIDTH-1:0] sub_diff;
  logic [31:0]               shamt;
  logic [DATAPATH_WIDTH-1:0] prod_next;
  logic                      last_iter;
  logic                      accept;

  // 0xDEAF tiled from bit 0 upward, cut to the datapath width
  genvar gi;
  generate
    for (gi = 0; gi < DATAPATH_WIDTH; gi++) begin : g_sentinel
      assign sentinel[gi] = SENTINEL_WORD[gi % 16];
    end
  endgenerate

  assign add_full  = {1'b0, bus.a_in} + {1'b0, bus.b_in};
  assign sub_diff  = bus.a_in - bus.b_in;
  assign shamt     = 32'(bus.shift_value) % 32'(DATAPATH_WIDTH);
  assign prod_next = prod_reg + (mplier_reg[0] ? mcand_reg : '0);
  assign last_iter = (cnt_reg == CW'(DATAPATH_WIDTH - 1));
  assign accept    = bus.op_valid_in && ready_reg;

  // Single-cycle result and flags, computed straight from the live inputs so
  // that the acceptance edge captures them.
  always_comb begin
    result_next = '0;
    carry_next  = 1'b0;
    ovf_next    = 1'b0;
    case (bus.alu_ctrl_in)
      OP_SENT: result_next = sentinel;
      OP_ADD: begin
        result_next = add_full[MSB:0];
        carry_next  = add_full[DATAPATH_WIDTH];
        ovf_next    = (bus.a_in[MSB] == bus.b_in[MSB]) &&
                      (add_full[MSB] != bus.a_in[MSB]);
      end
      OP_SUB: begin
        result_next = sub_diff;
        carry_next  = (bus.a_in < bus.b_in);
        ovf_next    = (bus.a_in[MSB] != bus.b_in[MSB]) &&
                      (sub_diff[MSB] != bus.a_in[MSB]);
      end
      OP_AND:  result_next = bus.a_in & bus.b_in;
      OP_OR:   result_next = bus.a_in | bus.b_in;
      OP_NOT:  result_next = ~bus.a_in;
      OP_XOR:  result_next = bus.a_in ^ bus.b_in;
      OP_SLTU: result_next = {{(DATAPATH_WIDTH-1){1'b0}}, (bus.a_in < bus.b_in)};
      OP_SLL:  result_next = bus.a_in << shamt;
      OP_SRL:  result_next = bus.a_in >> shamt;
      OP_SRA:  result_next = DATAPATH_WIDTH'($signed(bus.a_in) >>> shamt);
      OP_SLT:  result_next = {{(DATAPATH_WIDTH-1){1'b0}},
                              ($signed(bus.a_in) < $signed(bus.b_in))};
      default: result_next = '0;
    endcase
  end

  // Control FSM with registered handshake, status, result and flag outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg  <= IDLE;
      ready_reg  <= 1'b1;
      busy_reg   <= 1'b0;
      valid_reg  <= 1'b0;
      accum_reg  <= '0;
      zero_reg   <= 1'b0;
      carry_reg  <= 1'b0;
      ovf_reg    <= 1'b0;
      mcand_reg  <= '0;
      mplier_reg <= '0;
      prod_reg   <= '0;
      cnt_reg    <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            ready_reg <= 1'b0;
            busy_reg  <= 1'b1;
            if (bus.alu_ctrl_in == OP_MUL) begin
              state_reg  <= MUL;
              mcand_reg  <= bus.a_in;
              mplier_reg <= bus.b_in;
              prod_reg   <= '0;
              cnt_reg    <= '0;
            end else begin
              state_reg <= DONE;
              valid_reg <= 1'b1;
              accum_reg <= result_next;
              zero_reg  <= (result_next == '0);
              carry_reg <= carry_next;
              ovf_reg   <= ovf_next;
            end
          end
        end
        MUL: begin
          // One multiplier bit per cycle; operands live only in the shift regs
          prod_reg   <= prod_next;
          mcand_reg  <= mcand_reg << 1;
          mplier_reg <= mplier_reg >> 1;
          cnt_reg    <= cnt_reg + 1'b1;
          if (last_iter) begin
            state_reg <= DONE;
            valid_reg <= 1'b1;
            accum_reg <= prod_next;
            zero_reg  <= (prod_next == '0);
            carry_reg <= 1'b0;
            ovf_reg   <= 1'b0;
          end
        end
        DONE: begin
          if (bus.res_ready_in) begin
            state_reg <= IDLE;
            valid_reg <= 1'b0;
            busy_reg  <= 1'b0;
            ready_reg <= 1'b1;
          end
        end
        default: begin
          state_reg <= IDLE;
          ready_reg <= 1'b1;
          busy_reg  <= 1'b0;
          valid_reg <= 1'b0;
        end
      endcase
    end
  end

  assign bus.op_ready_out  = ready_reg;
  assign bus.busy_out      = busy_reg;
  assign bus.res_valid_out = valid_reg;
  assign bus.accum_out     = accum_reg;
  assign bus.zero_out      = zero_reg;
  assign bus.carry_out     = carry_reg;
  assign bus.ovf_out       = ovf_reg;

endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe: reset, every opcode, MUL timing, back-pressure,
// reset abort and back-to-back issue.
module tb_alu_pipe;
  localparam int W  = 64;
  localparam int SW = 6;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  alu_pipe_if #(.DATAPATH_WIDTH(W), .SHAMT_WIDTH(SW)) bus ();

  alu_pipe #(.DATAPATH_WIDTH(W), .SHAMT_WIDTH(SW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct {
    logic [3:0]    op;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [SW-1:0] sh;
    logic [W-1:0]  exp;
    logic [2:0]    zcv;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input logic [3:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [SW-1:0] sh,
                         input logic [W-1:0] exp, input logic [2:0] zcv);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.sh = sh; v.exp = exp; v.zcv = zcv;
    vecs.push_back(v);
  endtask

  // Present one request and return #1 after the edge that accepts it
  task automatic issue(input logic [3:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [SW-1:0] sh);
    bus.alu_ctrl_in = op;
    bus.a_in        = a;
    bus.b_in        = b;
    bus.shift_value = sh;
    bus.op_valid_in = 1'b1;
    @(posedge clk); #1;
    bus.op_valid_in = 1'b0;
  endtask

  task automatic release_result();
    bus.res_ready_in = 1'b1;
    @(posedge clk); #1;
    bus.res_ready_in = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.op_valid_in = 1'b0; bus.res_ready_in = 1'b0;
    bus.a_in = '0; bus.b_in = '0; bus.alu_ctrl_in = '0; bus.shift_value = '0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (bus.res_valid_out !== 1'b0 || bus.busy_out !== 1'b0) begin
      n_err++;
      $display("FAIL reset_status: valid=%b busy=%b want 0 0", bus.res_valid_out, bus.busy_out);
    end
    n_cmp++;
    if (bus.accum_out !== '0 || {bus.zero_out, bus.carry_out, bus.ovf_out} !== 3'b000) begin
      n_err++;
      $display("FAIL reset_data: accum=%h zcv=%b want 0 000", bus.accum_out,
               {bus.zero_out, bus.carry_out, bus.ovf_out});
    end
    reset = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if (bus.op_ready_out !== 1'b1) begin
      n_err++;
      $display("FAIL reset_ready: got %b want 1", bus.op_ready_out);
    end
    $display("[tb] reset released");
  endtask

  task automatic test_alu_ops();
    logic [W-1:0] a1 = 64'hF0F0_0000_1234_5678;
    logic [W-1:0] b1 = 64'h0FF0_0000_FFFF_0001;
    add_vec(4'd0,  '0, '0, 6'd0, 64'hDEAF_DEAF_DEAF_DEAF, 3'b000);
    add_vec(4'd1,  64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 6'd0, 64'd0, 3'b110);
    add_vec(4'd1,  64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 6'd0, 64'h8000_0000_0000_0000, 3'b001);
    add_vec(4'd1,  64'd2, 64'd3, 6'd0, 64'd5, 3'b000);
    add_vec(4'd2,  64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 6'd0,
            64'h8000_0000_0000_0000, 3'b011);
    add_vec(4'd2,  64'd5, 64'd7, 6'd0, 64'hFFFF_FFFF_FFFF_FFFE, 3'b010);
    add_vec(4'd2,  64'd3, 64'd3, 6'd0, 64'd0, 3'b100);
    add_vec(4'd3,  a1, b1, 6'd0, 64'h00F0_0000_1234_0000, 3'b000);
    add_vec(4'd4,  a1, b1, 6'd0, 64'hFFF0_0000_FFFF_5679, 3'b000);
    add_vec(4'd5,  a1, b1, 6'd0, 64'h0F0F_FFFF_EDCB_A987, 3'b000);
    add_vec(4'd6,  a1, b1, 6'd0, 64'hFF00_0000_EDCB_5679, 3'b000);
    add_vec(4'd7,  a1, b1, 6'd0, 64'd0, 3'b100);
    add_vec(4'd7,  b1, a1, 6'd0, 64'd1, 3'b000);
    add_vec(4'd11, a1, b1, 6'd0, 64'd1, 3'b000);
    add_vec(4'd11, b1, a1, 6'd0, 64'd0, 3'b100);
    add_vec(4'd8,  64'd1, b1, 6'd4, 64'h10, 3'b000);
    add_vec(4'd8,  64'd3, b1, 6'd63, 64'h8000_0000_0000_0000, 3'b000);
    add_vec(4'd8,  a1, b1, 6'd0, a1, 3'b000);
    add_vec(4'd8,  a1, b1, 6'd4, 64'h0F00_0001_2345_6780, 3'b000);
    add_vec(4'd9,  64'h8000_0000_0000_0000, b1, 6'd63, 64'd1, 3'b000);
    add_vec(4'd9,  a1, b1, 6'd4, 64'h0F0F_0000_0123_4567, 3'b000);
    add_vec(4'd10, 64'h8000_0000_0000_0000, b1, 6'd63, 64'hFFFF_FFFF_FFFF_FFFF, 3'b000);
    add_vec(4'd10, 64'h4000_0000_0000_0000, b1, 6'd62, 64'd1, 3'b000);
    add_vec(4'd10, a1, b1, 6'd4, 64'hFF0F_0000_0123_4567, 3'b000);
    add_vec(4'd10, a1, b1, 6'd0, a1, 3'b000);
    add_vec(4'd13, a1, b1, 6'd0, 64'd0, 3'b100);
    add_vec(4'd15, a1, b1, 6'd0, 64'd0, 3'b100);
    for (int i = 0; i < vecs.size(); i++) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].sh);
      $display("[tb] op=%0d a=%h b=%h sh=%0d -> accum=%h zcv=%b", vecs[i].op, vecs[i].a,
               vecs[i].b, vecs[i].sh, bus.accum_out, {bus.zero_out, bus.carry_out, bus.ovf_out});
      n_cmp++;
      if (bus.res_valid_out !== 1'b1 || bus.op_ready_out !== 1'b0 || bus.busy_out !== 1'b1) begin
        n_err++;
        $display("FAIL op%0d_latency: valid=%b ready=%b busy=%b want 1 0 1", i,
                 bus.res_valid_out, bus.op_ready_out, bus.busy_out);
      end
      n_cmp++;
      if (bus.accum_out !== vecs[i].exp) begin
        n_err++;
        $display("FAIL op%0d_accum: got %h want %h", i, bus.accum_out, vecs[i].exp);
      end
      n_cmp++;
      if ({bus.zero_out, bus.carry_out, bus.ovf_out} !== vecs[i].zcv) begin
        n_err++;
        $display("FAIL op%0d_flags: zcv got %b want %b", i,
                 {bus.zero_out, bus.carry_out, bus.ovf_out}, vecs[i].zcv);
      end
      release_result();
      n_cmp++;
      if (bus.res_valid_out !== 1'b0 || bus.op_ready_out !== 1'b1) begin
        n_err++;
        $display("FAIL op%0d_release: valid=%b ready=%b want 0 1", i,
                 bus.res_valid_out, bus.op_ready_out);
      end
    end
  endtask

  task automatic test_mul();
    logic [W-1:0] ma [4] = '{64'h12345, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1_0000_0001,
                             64'h8000_0000_0000_0000};
    logic [W-1:0] mb [4] = '{64'h10, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1_0000_0001, 64'd2};
    logic [W-1:0] me [4] = '{64'h123450, 64'd1, 64'h0000_0002_0000_0001, 64'd0};
    for (int i = 0; i < 4; i++) begin
      int lat;
      int ready_bad;
      issue(4'd12, ma[i], mb[i], 6'd0);
      lat = 1;
      ready_bad = 0;
      while (bus.res_valid_out !== 1'b1 && lat < 200) begin
        if (bus.op_ready_out !== 1'b0 || bus.busy_out !== 1'b1) ready_bad++;
        // Disturb the inputs; the multiply in flight must not see them
        bus.a_in = {$urandom, $urandom};
        bus.b_in = {$urandom, $urandom};
        bus.alu_ctrl_in = 4'd1;
        bus.op_valid_in = lat[0];
        @(posedge clk); #1;
        lat++;
      end
      bus.op_valid_in = 1'b0;
      $display("[tb] mul a=%h b=%h -> accum=%h after %0d cycles", ma[i], mb[i],
               bus.accum_out, lat);
      n_cmp++;
      if (lat != W + 1) begin
        n_err++;
        $display("FAIL mul%0d_latency: got %0d cycles want %0d", i, lat, W + 1);
      end
      n_cmp++;
      if (ready_bad != 0) begin
        n_err++;
        $display("FAIL mul%0d_ready_low: %0d cycles with ready/busy wrong, want 0", i, ready_bad);
      end
      n_cmp++;
      if (bus.accum_out !== me[i]) begin
        n_err++;
        $display("FAIL mul%0d_accum: got %h want %h", i, bus.accum_out, me[i]);
      end
      n_cmp++;
      if ({bus.zero_out, bus.carry_out, bus.ovf_out} !== {me[i] == '0, 2'b00}) begin
        n_err++;
        $display("FAIL mul%0d_flags: zcv got %b want %b", i,
                 {bus.zero_out, bus.carry_out, bus.ovf_out}, {me[i] == '0, 2'b00});
      end
      release_result();
    end
  endtask

  task automatic test_backpressure();
    int unstable = 0;
    issue(4'd2, 64'd1, 64'd2, 6'd0);
    for (int c = 0; c < 10; c++) begin
      bus.op_valid_in = 1'b1;
      bus.alu_ctrl_in = 4'd1;
      bus.a_in = 64'd0;
      bus.b_in = 64'(c);
      @(posedge clk); #1;
      if (bus.res_valid_out !== 1'b1 || bus.accum_out !== 64'hFFFF_FFFF_FFFF_FFFF ||
          {bus.zero_out, bus.carry_out, bus.ovf_out} !== 3'b010 || bus.op_ready_out !== 1'b0)
        unstable++;
    end
    bus.op_valid_in = 1'b0;
    $display("[tb] held SUB 1-2 for 10 cycles, accum=%h", bus.accum_out);
    n_cmp++;
    if (unstable != 0) begin
      n_err++;
      $display("FAIL hold_stable: %0d unstable cycles want 0", unstable);
    end
    release_result();
    n_cmp++;
    if (bus.op_ready_out !== 1'b1 || bus.busy_out !== 1'b0 || bus.res_valid_out !== 1'b0) begin
      n_err++;
      $display("FAIL hold_release: ready=%b busy=%b valid=%b want 1 0 0",
               bus.op_ready_out, bus.busy_out, bus.res_valid_out);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (bus.res_valid_out !== 1'b0 || bus.busy_out !== 1'b0) begin
      n_err++;
      $display("FAIL hold_no_queue: valid=%b busy=%b want 0 0", bus.res_valid_out, bus.busy_out);
    end
  endtask

  task automatic test_reset_abort();
    int seen = 0;
    issue(4'd12, 64'h12345, 64'h10, 6'd0);
    repeat (19) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    n_cmp++;
    if (bus.res_valid_out !== 1'b0 || bus.busy_out !== 1'b0 || bus.op_ready_out !== 1'b1 ||
        bus.accum_out !== '0 || {bus.zero_out, bus.carry_out, bus.ovf_out} !== 3'b000) begin
      n_err++;
      $display("FAIL abort_outputs: valid=%b busy=%b ready=%b accum=%h want 0 0 1 0",
               bus.res_valid_out, bus.busy_out, bus.op_ready_out, bus.accum_out);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    for (int c = 0; c < 80; c++) begin
      @(posedge clk); #1;
      if (bus.res_valid_out !== 1'b0) seen++;
    end
    n_cmp++;
    if (seen != 0) begin
      n_err++;
      $display("FAIL abort_no_result: valid seen %0d cycles want 0", seen);
    end
    issue(4'd1, 64'd2, 64'd3, 6'd0);
    $display("[tb] after abort ADD 2+3 -> accum=%h", bus.accum_out);
    n_cmp++;
    if (bus.res_valid_out !== 1'b1 || bus.accum_out !== 64'd5) begin
      n_err++;
      $display("FAIL abort_next_add: valid=%b accum=%h want 1 5", bus.res_valid_out, bus.accum_out);
    end
    release_result();
  endtask

  task automatic test_back_to_back();
    logic [3:0]   ops [3] = '{4'd1, 4'd2, 4'd6};
    logic [W-1:0] as  [3] = '{64'd1, 64'd10, 64'hF0};
    logic [W-1:0] bs  [3] = '{64'd1, 64'd4, 64'h0F};
    logic [W-1:0] es  [3] = '{64'd2, 64'd6, 64'hFF};
    int k = 0;
    int edges = 0;
    int last_edge = 0;
    bus.res_ready_in = 1'b1;
    bus.alu_ctrl_in = ops[0]; bus.a_in = as[0]; bus.b_in = bs[0]; bus.shift_value = '0;
    bus.op_valid_in = 1'b1;
    while (k < 3 && edges < 20) begin
      @(posedge clk); #1;
      edges++;
      if (bus.res_valid_out === 1'b1) begin
        $display("[tb] b2b #%0d accum=%h at edge %0d", k, bus.accum_out, edges);
        n_cmp++;
        if (bus.accum_out !== es[k]) begin
          n_err++;
          $display("FAIL b2b%0d_accum: got %h want %h", k, bus.accum_out, es[k]);
        end
        k++;
        last_edge = edges;
        if (k < 3) begin
          bus.alu_ctrl_in = ops[k]; bus.a_in = as[k]; bus.b_in = bs[k];
        end else begin
          bus.op_valid_in = 1'b0;
        end
      end
    end
    bus.op_valid_in = 1'b0;
    n_cmp++;
    if (k != 3 || last_edge != 5) begin
      n_err++;
      $display("FAIL b2b_throughput: results=%0d last_edge=%0d want 3 5", k, last_edge);
    end
    @(posedge clk); #1;
    bus.res_ready_in = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_alu_ops();
    test_mul();
    test_backpressure();
    test_reset_abort();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
